// File: rtl/axis_integrator_if.sv
// Command/response bundle for axis_integrator: step handshake, per-axis operand
// buses and the position/velocity/overflow state outputs.
interface axis_if #(
    parameter int WIDTH = 16,
    parameter int AXES  = 3
);
    logic                    step_valid;
    logic                    step_ready;
    logic [1:0]              mode;
    logic [AXES*WIDTH-1:0]   accel;
    logic [AXES*WIDTH-1:0]   load_pos;
    logic [AXES*WIDTH-1:0]   load_vel;
    logic [AXES*WIDTH-1:0]   pos;
    logic [AXES*WIDTH-1:0]   vel;
    logic                    out_valid;
    logic [AXES-1:0]         ovf;

    modport master (
        output step_valid, mode, accel, load_pos, load_vel,
        input  step_ready, pos, vel, out_valid, ovf
    );

    modport slave (
        input  step_valid, mode, accel, load_pos, load_vel,
        output step_ready, pos, vel, out_valid, ovf
    );
endinterface

// File: rtl/axis_integrator.sv
// Multi-axis Euler integrator: vel += accel, then pos += vel, axis by axis,
// sharing a single saturating/wrapping WIDTH-bit adder across all updates.
module axis_integrator #(
    parameter int WIDTH = 16,
    parameter int AXES  = 3,
    parameter int SAT   = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    axis_if.slave bus
);
    localparam int AW = (AXES > 1) ? $clog2(AXES) : 1;

    typedef enum logic [1:0] {IDLE, VEL, POS, DONE} state_t;

    state_t                      state;
    logic [AW-1:0]               ax;
    logic [AXES-1:0][WIDTH-1:0]  pos_q, vel_q, acc_q;
    logic [AXES-1:0]             ovf_q;
    logic                        ready, out_valid;

    logic [WIDTH-1:0] op_a, op_b, sum, res;
    logic             ovf_add;

    // Shared adder: VEL adds latched accel to vel, POS adds the fresh vel to pos.
    always_comb begin
        op_a    = (state == POS) ? pos_q[ax] : vel_q[ax];
        op_b    = (state == POS) ? vel_q[ax] : acc_q[ax];
        sum     = op_a + op_b;
        ovf_add = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        res     = sum;
        if (SAT != 0 && ovf_add)
            res = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ax        <= '0;
            pos_q     <= '0;
            vel_q     <= '0;
            acc_q     <= '0;
            ovf_q     <= '0;
            ready     <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.step_valid && ready) begin
                        acc_q     <= bus.accel;
                        ready     <= 1'b0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                        case (bus.mode)
                            2'b01: begin
                                pos_q <= bus.load_pos;
                                vel_q <= bus.load_vel;
                                ovf_q <= '0;
                            end
                            2'b10: begin
                                ax        <= '0;
                                state     <= VEL;
                                out_valid <= 1'b0;
                            end
                            2'b11: begin
                                pos_q <= '0;
                                vel_q <= '0;
                                ovf_q <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                VEL: begin
                    vel_q[ax] <= res;
                    ovf_q[ax] <= ovf_q[ax] | ovf_add;
                    state     <= POS;
                end
                POS: begin
                    pos_q[ax] <= res;
                    ovf_q[ax] <= ovf_q[ax] | ovf_add;
                    if (ax == AW'(AXES - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        ax    <= ax + 1'b1;
                        state <= VEL;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    ready     <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.step_ready = ready;
    assign bus.out_valid  = out_valid;
    assign bus.pos        = pos_q;
    assign bus.vel        = vel_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_axis_integrator.sv
// Drives a saturating and a wrapping integrator in lockstep and compares both
// against an integer-arithmetic reference model.
module tb_axis_integrator;
    localparam int W = 16, A = 3;
    localparam int MAXV = 32767, MINV = -32768;

    logic           clk = 1'b0, rst_n = 1'b0;
    logic           valid = 1'b0;
    logic [1:0]     mode = 2'b00;
    logic [A*W-1:0] accel = '0, lpos = '0, lvel = '0;

    always #5 clk = ~clk;

    axis_if #(.WIDTH(W), .AXES(A)) b1 ();
    axis_if #(.WIDTH(W), .AXES(A)) b0 ();

    assign b1.step_valid = valid;  assign b0.step_valid = valid;
    assign b1.mode       = mode;   assign b0.mode       = mode;
    assign b1.accel      = accel;  assign b0.accel      = accel;
    assign b1.load_pos   = lpos;   assign b0.load_pos   = lpos;
    assign b1.load_vel   = lvel;   assign b0.load_vel   = lvel;

    axis_integrator #(.WIDTH(W), .AXES(A), .SAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    axis_integrator #(.WIDTH(W), .AXES(A), .SAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    int         n_vec = 0, n_err = 0;
    int         mp[2][A], mv[2][A];
    logic [A-1:0] mo[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sadd(input int a, input int b, input int sat, output bit o);
        int s;
        s = a + b;
        o = 1'b0;
        if (s > MAXV) begin o = 1'b1; s = (sat != 0) ? MAXV : s - 65536; end
        else if (s < MINV) begin o = 1'b1; s = (sat != 0) ? MINV : s + 65536; end
        return s;
    endfunction

    function automatic logic [A*W-1:0] mpack(input int s, input bit is_vel);
        logic [A*W-1:0] r;
        int             v;
        for (int i = 0; i < A; i++) begin
            v = is_vel ? mv[s][i] : mp[s][i];
            r[i*W +: W] = v[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [A*W-1:0] vpack(input int v[A]);
        logic [A*W-1:0] r;
        int             t;
        for (int i = 0; i < A; i++) begin
            t = v[i];
            r[i*W +: W] = t[W-1:0];
        end
        return r;
    endfunction

    function automatic int rnd();
        logic signed [W-1:0] t;
        if ($urandom_range(0, 3) == 0) begin
            t = W'($urandom);
            return int'(t);
        end
        return int'($urandom_range(0, 64)) - 32;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < A; i++) begin mp[s][i] = 0; mv[s][i] = 0; end
            mo[s] = '0;
        end
    endtask

    task automatic model_cmd(input logic [1:0] md, input int ac[A], input int lp[A], input int lv[A]);
        bit o;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < A; i++) begin
                case (md)
                    2'b01: begin mp[s][i] = lp[i]; mv[s][i] = lv[i]; mo[s][i] = 1'b0; end
                    2'b11: begin mp[s][i] = 0; mv[s][i] = 0; mo[s][i] = 1'b0; end
                    2'b10: begin
                        mv[s][i] = sadd(mv[s][i], ac[i], s, o);
                        if (o) mo[s][i] = 1'b1;
                        mp[s][i] = sadd(mp[s][i], mv[s][i], s, o);
                        if (o) mo[s][i] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".pos1"}, b1.pos, mpack(1, 0));
        chk({tag, ".vel1"}, b1.vel, mpack(1, 1));
        chk({tag, ".ovf1"}, b1.ovf, mo[1]);
        chk({tag, ".pos0"}, b0.pos, mpack(0, 0));
        chk({tag, ".vel0"}, b0.vel, mpack(0, 1));
        chk({tag, ".ovf0"}, b0.ovf, mo[0]);
    endtask

    // One command from an idle negedge through its out_valid pulse.
    task automatic do_cmd(input string tag, input logic [1:0] md, input int ac[A],
                          input int lp[A], input int lv[A]);
        int lat;
        bit done;
        @(negedge clk);
        chk({tag, ".ready"}, {b1.step_ready, b0.step_ready}, 2'b11);
        valid = 1'b1; mode = md; accel = vpack(ac); lpos = vpack(lp); lvel = vpack(lv);
        @(posedge clk);
        #1;
        valid = 1'b0; mode = 2'($urandom); accel = {$urandom, $urandom};
        model_cmd(md, ac, lp, lv);
        lat = 0; done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (b1.out_valid) done = 1'b1;
            else chk({tag, ".busy"}, {b1.step_ready, b0.step_ready, b0.out_valid}, 3'b000);
        end
        chk({tag, ".lat"}, 64'(lat), (md == 2'b10) ? 64'(2*A+1) : 64'd1);
        chk({tag, ".ov0"}, b0.out_valid, 1'b1);
        cmp_all(tag);
        @(negedge clk);
        chk({tag, ".pulse"}, {b1.out_valid, b0.out_valid, b1.step_ready, b0.step_ready}, 4'b0011);
    endtask

    initial begin
        int z[A], ac[A], lp[A], lv[A];
        int acc_at[$];
        int early_ready;
        bit seen;

        for (int i = 0; i < A; i++) z[i] = 0;
        model_reset();

        // Reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        cmp_all("reset");
        chk("reset.hs", {b1.step_ready, b0.step_ready, b1.out_valid, b0.out_valid}, 4'b1100);
        rst_n = 1'b1;

        // LOAD then zero-accel INTEGRATE
        lp = '{100, -5, 0}; lv = '{1, 2, 3};
        do_cmd("load", 2'b01, z, lp, lv);
        do_cmd("int_zero_acc", 2'b10, z, z, z);
        chk("int_zero_acc.lit_pos", b1.pos, {16'd3, 16'hfffd, 16'd101});
        chk("int_zero_acc.lit_vel", b1.vel, {16'd3, 16'd2, 16'd1});

        // ZERO then two INTEGRATEs
        do_cmd("zero", 2'b11, z, z, z);
        ac = '{2, -1, 0};
        do_cmd("int1", 2'b10, ac, z, z);
        do_cmd("int2", 2'b10, ac, z, z);
        chk("int2.lit_pos", b1.pos, {16'd0, 16'hfffd, 16'd6});
        chk("int2.lit_vel", b1.vel, {16'd0, 16'hfffe, 16'd4});

        // Overflow: saturating vs wrapping, then ZERO clears flags
        lp = '{32767, 0, 0}; lv = '{32767, 0, 0}; ac = '{1, 0, 0};
        do_cmd("ovf_load", 2'b01, z, lp, lv);
        do_cmd("ovf_int", 2'b10, ac, z, z);
        chk("ovf.sat_pv", {b1.vel[15:0], b1.pos[15:0], b1.ovf}, {16'h7fff, 16'h7fff, 3'b001});
        chk("ovf.wrap_pv", {b0.vel[15:0], b0.pos[15:0], b0.ovf}, {16'h8000, 16'hffff, 3'b001});
        do_cmd("ovf_clear", 2'b11, z, z, z);
        chk("ovf_clear.lit", {b1.ovf, b0.ovf}, 6'b0);

        // HOLD leaves registers alone
        lp = '{7, -7, 1234}; lv = '{-3, 4, 5};
        do_cmd("hold_load", 2'b01, z, lp, lv);
        do_cmd("hold", 2'b00, z, z, z);

        // Reset during POS of axis 1 aborts the command
        @(negedge clk);
        valid = 1'b1; mode = 2'b10; accel = vpack('{5, 6, 7});
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        cmp_all("midrst");
        chk("midrst.hs", {b1.step_ready, b0.step_ready, b1.out_valid, b0.out_valid}, 4'b1100);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (b1.out_valid || b0.out_valid) seen = 1'b1;
        end
        chk("midrst.no_pulse", seen, 1'b0);

        // step_valid held high: one accept per IDLE visit
        ac = '{3, -2, 1};
        @(negedge clk);
        valid = 1'b1; mode = 2'b10; accel = vpack(ac);
        early_ready = 0;
        for (int c = 0; c < 20; c++) begin
            if (b1.step_ready) acc_at.push_back(c);
            if (b1.step_ready && c >= 1 && c <= 7) early_ready++;
            @(negedge clk);
        end
        valid = 1'b0;
        for (int k = 0; k < acc_at.size(); k++) model_cmd(2'b10, ac, z, z);
        chk("held.count", 64'(acc_at.size()), 64'd3);
        if (acc_at.size() >= 2) begin
            chk("held.acc0", 64'(acc_at[0]), 64'd0);
            chk("held.acc1", 64'(acc_at[1]), 64'd8);
        end
        chk("held.ready_low", 64'(early_ready), 64'd0);
        for (int k = 0; k < 12 && !b1.step_ready; k++) @(negedge clk);
        chk("held.idle", {b1.step_ready, b0.step_ready}, 2'b11);
        cmp_all("held");

        // Randomized command mix
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < A; i++) begin ac[i] = rnd(); lp[i] = rnd(); lv[i] = rnd(); end
            do_cmd("rand", 2'($urandom_range(0, 3)), ac, lp, lv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
